// File: rtl/theia_omem_drain.sv
// Readback engine for the THEIA output memories: sweeps enabled cores bank by bank,
// absorbs the one-cycle read latency and emits a strobe/ack stream tagged with the core.
module theia_omem_drain #(
  parameter int WB_WIDTH      = 32,
  parameter int MAX_CORES     = 8,
  parameter int MAX_CORE_BITS = 3
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     START_I,
  input  logic [WB_WIDTH-1:0]      WCNT_I,
  input  logic [MAX_CORES-1:0]     CMASK_I,
  output logic [MAX_CORE_BITS-1:0] OMBSEL_O,
  output logic [WB_WIDTH-1:0]      OMADR_O,
  input  logic [WB_WIDTH-1:0]      OMEM_I,
  output logic [WB_WIDTH-1:0]      DAT_O,
  output logic [MAX_CORE_BITS-1:0] TGA_O,
  output logic                     STB_O,
  input  logic                     ACK_I,
  output logic                     BUSY_O,
  output logic                     DONE_O
);

  // state | meaning
  // IDLE  | waiting for START_I
  // READ  | issuing reads, one per cycle while credit allows
  // FLUSH | all reads issued, draining in-flight word and FIFO
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]               r_state;
  logic [WB_WIDTH-1:0]      r_wcnt;
  logic [MAX_CORES-1:0]     r_cmask;
  logic [MAX_CORE_BITS-1:0] r_core;
  logic [WB_WIDTH-1:0]      r_addr;
  logic                     r_vld;
  logic [MAX_CORE_BITS-1:0] r_vld_tga;
  logic [WB_WIDTH-1:0]      r_fifo_dat [2];
  logic [MAX_CORE_BITS-1:0] r_fifo_tga [2];
  logic                     r_rptr;
  logic                     r_wptr;
  logic [1:0]               r_occ;
  logic                     r_done;

  logic [MAX_CORE_BITS-1:0] w_first;
  logic [MAX_CORE_BITS-1:0] w_next;
  logic                     w_has_next;
  logic                     w_pop;
  logic [1:0]               w_level;
  logic                     w_issue;
  logic [WB_WIDTH-1:0]      w_last_adr;

  always_comb begin
    w_first = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--)
      if (CMASK_I[i]) w_first = MAX_CORE_BITS'(i);
  end

  always_comb begin
    w_next     = r_core;
    w_has_next = 1'b0;
    for (int i = MAX_CORES - 1; i >= 0; i--)
      if (r_cmask[i] && (MAX_CORE_BITS'(i) > r_core)) begin
        w_next     = MAX_CORE_BITS'(i);
        w_has_next = 1'b1;
      end
  end

  // Level is the FIFO occupancy after this edge; a read issued now lands one cycle later,
  // so allowing issue at level<=1 keeps the 2-entry FIFO from overflowing.
  assign w_pop      = STB_O & ACK_I;
  assign w_level    = r_occ + {1'b0, r_vld} - {1'b0, w_pop};
  assign w_issue    = (r_state == S_READ) && (w_level <= 2'd1);
  assign w_last_adr = r_wcnt - WB_WIDTH'(1);

  assign OMBSEL_O = r_core;
  assign OMADR_O  = r_addr;
  assign DAT_O    = r_fifo_dat[r_rptr];
  assign TGA_O    = r_fifo_tga[r_rptr];
  assign STB_O    = (r_occ != 2'd0);
  assign BUSY_O   = (r_state != S_IDLE);
  assign DONE_O   = r_done;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_cmask       <= '0;
      r_core        <= '0;
      r_addr        <= '0;
      r_vld         <= 1'b0;
      r_vld_tga     <= '0;
      r_fifo_dat[0] <= '0;
      r_fifo_dat[1] <= '0;
      r_fifo_tga[0] <= '0;
      r_fifo_tga[1] <= '0;
      r_rptr        <= 1'b0;
      r_wptr        <= 1'b0;
      r_occ         <= 2'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= w_issue;
      r_occ  <= w_level;
      if (w_issue) r_vld_tga <= r_core;
      if (r_vld) begin
        r_fifo_dat[r_wptr] <= OMEM_I;
        r_fifo_tga[r_wptr] <= r_vld_tga;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;

      case (r_state)
        S_IDLE: begin
          if (START_I) begin
            r_wcnt  <= WCNT_I;
            r_cmask <= CMASK_I;
            if ((WCNT_I == '0) || (CMASK_I == '0)) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_core  <= w_first;
              r_addr  <= '0;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_addr == w_last_adr) begin
              if (w_has_next) begin
                r_core <= w_next;
                r_addr <= '0;
              end else begin
                r_state <= S_FLUSH;
              end
            end else begin
              r_addr <= r_addr + WB_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          if (w_level == 2'd0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_theia_omem_drain.sv
// Self-checking bench for theia_omem_drain: synchronous memory model plus an in-order
// scoreboard of (core, word) filled at start and drained on every handshake.
module tb_theia_omem_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] wcnt;
  logic [7:0]  cmask;
  logic [2:0]  ombsel;
  logic [31:0] omadr;
  logic [31:0] omem;
  logic [31:0] dat;
  logic [2:0]  tga;
  logic        stb;
  logic        ack;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  logic [34:0] sb_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat;
  logic [2:0]  prev_tga;

  theia_omem_drain #(.WB_WIDTH(32), .MAX_CORES(8), .MAX_CORE_BITS(3)) dut (
    .CLK_I(clk), .RST_I(rst_n), .START_I(start), .WCNT_I(wcnt), .CMASK_I(cmask),
    .OMBSEL_O(ombsel), .OMADR_O(omadr), .OMEM_I(omem),
    .DAT_O(dat), .TGA_O(tga), .STB_O(stb), .ACK_I(ack),
    .BUSY_O(busy), .DONE_O(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [2:0] b, input logic [31:0] a);
    return {b, 5'h0A, 24'h0} ^ (a * 32'h0001_0003) ^ 32'h0000_5A5A;
  endfunction

  // Output memory: one-cycle synchronous read
  always @(posedge clk) omem <= mem_f(ombsel, omadr);

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (stb !== 1'b1 || dat !== prev_dat || tga !== prev_tga)
          $display("FAIL stall_hold: stb=%b tga=%0d dat=%h, required stb=1 tga=%0d dat=%h",
                   stb, tga, dat, prev_tga, prev_dat);
        else n_pass++;
      end
      if (done) begin
        n_checks++;
        if (stb !== 1'b0) $display("FAIL done_with_stb: stb=%b, required 0", stb);
        else n_pass++;
      end
      if (stb && ack) begin
        logic [34:0] exp_w;
        n_checks++;
        n_xfer++;
        if (sb_q.size() == 0) begin
          $display("FAIL stream_extra: tga=%0d dat=%h, required no transfer", tga, dat);
        end else begin
          exp_w = sb_q.pop_front();
          if ({tga, dat} !== exp_w)
            $display("FAIL stream_word: tga=%0d dat=%h, required tga=%0d dat=%h",
                     tga, dat, exp_w[34:32], exp_w[31:0]);
          else n_pass++;
        end
      end
      prev_stall = stb && !ack;
      prev_dat   = dat;
      prev_tga   = tga;
    end
  end

  task automatic push_expected(input logic [7:0] cm, input logic [31:0] wc);
    for (int c = 0; c < 8; c++)
      if (cm[c])
        for (int a = 0; a < int'(wc); a++)
          sb_q.push_back({3'(c), mem_f(3'(c), 32'(a))});
  endtask

  task automatic start_run(input logic [7:0] cm, input logic [31:0] wc);
    @(posedge clk); #1;
    start = 1'b1;
    cmask = cm;
    wcnt  = wc;
    ack   = 1'b1;
  endtask

  // Drives ACK until DONE_O is seen; cyc = cycles after the start cycle, or -1 on timeout.
  task automatic drive_until_done(input int budget, input bit rnd, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ack   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    @(posedge clk); #1;
    ack = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({ombsel, omadr, dat, tga, stb, busy, done} !== '0)
      $display("FAIL reset_outputs: bsel=%0d adr=%h dat=%h tga=%0d stb=%b busy=%b done=%b, required all 0",
               ombsel, omadr, dat, tga, stb, busy, done);
    else n_pass++;
  endtask

  task automatic test_single_core;
    logic [31:0] exp_adr;
    push_expected(8'h01, 32'd4);
    start_run(8'h01, 32'd4);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (c == 0) continue;
      exp_adr = (c <= 4) ? 32'(c - 1) : 32'd3;
      n_checks++;
      if (omadr !== exp_adr || ombsel !== 3'd0)
        $display("FAIL single_addr c=%0d: bsel=%0d adr=%0d, required bsel=0 adr=%0d", c, ombsel, omadr, exp_adr);
      else n_pass++;
      n_checks++;
      if (stb !== (c >= 3 && c <= 6))
        $display("FAIL single_stb c=%0d: stb=%b, required %b", c, stb, (c >= 3 && c <= 6));
      else n_pass++;
      n_checks++;
      if (done !== (c == 7) || busy !== (c >= 1 && c <= 6))
        $display("FAIL single_ctl c=%0d: done=%b busy=%b, required done=%b busy=%b",
                 c, done, busy, (c == 7), (c >= 1 && c <= 6));
      else n_pass++;
    end
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL single_left: %0d words left, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_multi_core;
    int first = -1, last = -1, cnt = 0, done_c = -1;
    push_expected(8'hA4, 32'd2);
    start_run(8'hA4, 32'd2);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (stb) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (done && done_c < 0) done_c = c;
    end
    n_checks++;
    if (first != 3 || last != 8 || cnt != 6)
      $display("FAIL multi_contig: first=%0d last=%0d count=%0d, required 3 8 6", first, last, cnt);
    else n_pass++;
    n_checks++;
    if (done_c != 9) $display("FAIL multi_done: cycle=%0d, required 9", done_c);
    else n_pass++;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL multi_left: %0d words left, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int cyc, x0;
    x0 = n_xfer;
    push_expected(8'hFF, 32'd16);
    start_run(8'hFF, 32'd16);
    drive_until_done(3000, 1'b1, cyc);
    n_checks++;
    if (cyc < 0 || n_xfer - x0 != 128 || sb_q.size() != 0)
      $display("FAIL backpressure: done_cyc=%0d transfers=%0d left=%0d, required done transfers=128 left=0",
               cyc, n_xfer - x0, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_cfg(input logic [7:0] cm, input logic [31:0] wc);
    logic [31:0] a0;
    logic [2:0]  b0;
    int          x0;
    a0 = omadr; b0 = ombsel; x0 = n_xfer;
    start_run(cm, wc);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      n_checks++;
      if (done !== (c == 1) || busy !== 1'b0 || stb !== 1'b0)
        $display("FAIL zero_ctl cm=%h wc=%0d c=%0d: done=%b busy=%b stb=%b, required done=%b busy=0 stb=0",
                 cm, wc, c, done, busy, stb, (c == 1));
      else n_pass++;
      n_checks++;
      if (omadr !== a0 || ombsel !== b0)
        $display("FAIL zero_addr c=%0d: bsel=%0d adr=%0d, required bsel=%0d adr=%0d", c, ombsel, omadr, b0, a0);
      else n_pass++;
    end
    n_checks++;
    if (n_xfer != x0) $display("FAIL zero_xfer: transfers=%0d, required 0", n_xfer - x0);
    else n_pass++;
  endtask

  task automatic test_restart_ignored;
    int cyc, x0;
    x0 = n_xfer;
    push_expected(8'hFF, 32'd3);
    start_run(8'hFF, 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ack   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b1;
    cmask = 8'h01;
    wcnt  = 32'd100;
    drive_until_done(2000, 1'b1, cyc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cyc < 0 || n_xfer - x0 != 24 || sb_q.size() != 0 || busy !== 1'b0)
      $display("FAIL restart_ignored: done_cyc=%0d transfers=%0d left=%0d busy=%b, required transfers=24 left=0 busy=0",
               cyc, n_xfer - x0, sb_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int cyc, x0;
    push_expected(8'hFF, 32'd16);
    start_run(8'hFF, 32'd16);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ack   = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ombsel, omadr, dat, tga, stb, busy, done} !== '0)
      $display("FAIL async_reset: bsel=%0d adr=%h dat=%h tga=%0d stb=%b busy=%b done=%b, required all 0",
               ombsel, omadr, dat, tga, stb, busy, done);
    else n_pass++;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stb !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: stb=%b busy=%b, required 0 0", stb, busy);
    else n_pass++;
    x0 = n_xfer;
    push_expected(8'h03, 32'd3);
    start_run(8'h03, 32'd3);
    drive_until_done(200, 1'b0, cyc);
    n_checks++;
    if (cyc != 8 || n_xfer - x0 != 6 || sb_q.size() != 0)
      $display("FAIL after_reset: done_cyc=%0d transfers=%0d left=%0d, required 8 6 0",
               cyc, n_xfer - x0, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    wcnt  = '0;
    cmask = '0;
    ack   = 1'b1;
    repeat (3) @(posedge clk);
    test_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_reset;
    test_single_core;
    test_multi_core;
    test_backpressure;
    test_zero_cfg(8'hFF, 32'd0);
    test_zero_cfg(8'h00, 32'd5);
    test_restart_ignored;
    test_reset_midrun;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
